// File: rtl/hydra_pkt_gen.sv
// hydra_pkt_gen: framed packet stimulus generator for the hydra write side.
// Drives PORT_NUM independent channels with sop / header / payload / eop frames,
// honours per-channel pause, and sequences dest/prio as fixed, incrementing or
// LFSR-random.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, stop           run launch (latches cfg_*) / graceful stop pulses
//   chan_en               per-channel enable, sampled at start
//   cfg_mode/len/prio/dest/gap/pkt_num   run configuration
//   pause                 per-channel backpressure (1-cycle response)
//   wr_sop/eop/vld/data   per-channel frame outputs, channel i at slice i
//   busy                  per-channel not-idle
//   done                  one-cycle pulse when the run completes
module hydra_pkt_gen #(
  parameter int unsigned PORT_NUM   = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 9,
  parameter int unsigned PRI_WIDTH  = 3,
  parameter int unsigned DEST_WIDTH = $clog2(PORT_NUM),
  parameter int unsigned GAP_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic [PORT_NUM-1:0]            chan_en,
  input  logic [1:0]                     cfg_mode,
  input  logic [LEN_WIDTH-1:0]           cfg_len,
  input  logic [PRI_WIDTH-1:0]           cfg_prio,
  input  logic [DEST_WIDTH-1:0]          cfg_dest,
  input  logic [GAP_WIDTH-1:0]           cfg_gap,
  input  logic [15:0]                    cfg_pkt_num,
  input  logic [PORT_NUM-1:0]            pause,
  output logic [PORT_NUM-1:0]            wr_sop,
  output logic [PORT_NUM-1:0]            wr_eop,
  output logic [PORT_NUM-1:0]            wr_vld,
  output logic [PORT_NUM*DATA_WIDTH-1:0] wr_data,
  output logic [PORT_NUM-1:0]            busy,
  output logic                           done
);

  localparam int unsigned CNT_WIDTH  = 16;
  localparam int unsigned LFSR_WIDTH = 16;

  typedef enum logic [2:0] {S_IDLE, S_SOP, S_HDR, S_PAY, S_EOP, S_GAP} state_t;

  logic [1:0]            cfg_mode_q;
  logic [LEN_WIDTH-1:0]  cfg_len_q;
  logic [PRI_WIDTH-1:0]  cfg_prio_q;
  logic [DEST_WIDTH-1:0] cfg_dest_q;
  logic [GAP_WIDTH-1:0]  cfg_gap_q;
  logic [CNT_WIDTH-1:0]  cfg_pkt_num_q;
  logic                  busy_d;
  logic                  any_busy;
  logic                  start_acc;

  // Effective config: on the accepting edge the live inputs are used so the
  // first sop can capture its header fields in the same cycle.
  logic [1:0]            eff_mode;
  logic [PRI_WIDTH-1:0]  eff_prio;
  logic [DEST_WIDTH-1:0] eff_dest;

  assign any_busy  = |busy;
  assign start_acc = start & ~any_busy;
  assign eff_mode  = start_acc ? cfg_mode : cfg_mode_q;
  assign eff_prio  = start_acc ? cfg_prio : cfg_prio_q;
  assign eff_dest  = start_acc ? cfg_dest : cfg_dest_q;

  // Shared config latch and run-completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_mode_q    <= '0;
      cfg_len_q     <= '0;
      cfg_prio_q    <= '0;
      cfg_dest_q    <= '0;
      cfg_gap_q     <= '0;
      cfg_pkt_num_q <= '0;
      busy_d        <= 1'b0;
      done          <= 1'b0;
    end else begin
      busy_d <= any_busy;
      done   <= (busy_d & ~any_busy) | (start_acc & ~(|chan_en));
      if (start_acc) begin
        cfg_mode_q    <= cfg_mode;
        cfg_len_q     <= cfg_len;
        cfg_prio_q    <= cfg_prio;
        cfg_dest_q    <= cfg_dest;
        cfg_gap_q     <= cfg_gap;
        cfg_pkt_num_q <= cfg_pkt_num;
      end
    end
  end

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_ch
    state_t                state_q, state_n;
    logic                  sop_q, sop_n, eop_q, eop_n, vld_q, vld_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic [LEN_WIDTH-1:0]  beat_q, beat_n;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_n;
    logic [CNT_WIDTH-1:0]  pkt_q, pkt_n;
    logic [DATA_WIDTH-1:0] pay_q, pay_n;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_n, lfsr_src, lfsr_adv;
    logic [DEST_WIDTH-1:0] nd_q, nd_n, nd_src;
    logic [DEST_WIDTH-1:0] hdr_dest_q, hdr_dest_n, cap_dest;
    logic [PRI_WIDTH-1:0]  hdr_prio_q, hdr_prio_n, cap_prio;
    logic                  stop_q, stop_n, armed_q, armed_n, busy_q, busy_n;
    logic                  launch_req, stop_now, do_sop;

    assign lfsr_src = start_acc ? LFSR_WIDTH'(i + 1) : lfsr_q;
    assign nd_src   = start_acc ? cfg_dest : nd_q;
    assign lfsr_adv = {lfsr_src[LFSR_WIDTH-2:0],
                       lfsr_src[15] ^ lfsr_src[13] ^ lfsr_src[12] ^ lfsr_src[10]};
    assign stop_now = stop_q | stop;
    // A launch blocked by pause stays armed until pause drops or stop arrives.
    assign launch_req = (start_acc & chan_en[i]) | (armed_q & ~stop);

    // Header fields captured whenever a sop is issued.
    always_comb begin
      cap_dest = eff_dest;
      cap_prio = eff_prio;
      case (eff_mode)
        2'd1: cap_dest = nd_src;
        2'd2: begin
          cap_dest = lfsr_src[DEST_WIDTH-1:0];
          cap_prio = lfsr_src[DEST_WIDTH +: PRI_WIDTH];
        end
        default: ;
      endcase
    end

    // Next-state and next-output logic; state_q names the beat currently on the bus.
    always_comb begin
      state_n    = state_q;
      sop_n      = 1'b0;
      eop_n      = 1'b0;
      vld_n      = 1'b0;
      data_n     = '0;
      beat_n     = beat_q;
      gap_cnt_n  = gap_cnt_q;
      pkt_n      = start_acc ? '0 : pkt_q;
      pay_n      = start_acc ? '0 : pay_q;
      lfsr_n     = lfsr_src;
      nd_n       = nd_src;
      hdr_dest_n = hdr_dest_q;
      hdr_prio_n = hdr_prio_q;
      stop_n     = stop_q | (stop & busy_q);
      armed_n    = 1'b0;
      do_sop     = 1'b0;
      if (state_q == S_IDLE) begin
        if (launch_req) begin
          if (pause[i]) armed_n = 1'b1;
          else begin
            state_n = S_SOP;
            do_sop  = 1'b1;
          end
        end
      end else if (!pause[i]) begin
        case (state_q)
          S_SOP: begin
            state_n = S_HDR;
            vld_n   = 1'b1;
            data_n  = DATA_WIDTH'({cfg_len_q, hdr_prio_q, hdr_dest_q});
          end
          S_HDR, S_PAY: begin
            if ((state_q == S_HDR && cfg_len_q == '0) ||
                (state_q == S_PAY && beat_q == cfg_len_q)) begin
              state_n = S_EOP;
              eop_n   = 1'b1;
              pkt_n   = pkt_q + CNT_WIDTH'(1);
            end else begin
              state_n = S_PAY;
              vld_n   = 1'b1;
              data_n  = pay_q;
              pay_n   = pay_q + DATA_WIDTH'(1);
              beat_n  = (state_q == S_HDR) ? LEN_WIDTH'(1) : beat_q + LEN_WIDTH'(1);
            end
          end
          S_EOP: begin
            if ((cfg_pkt_num_q != '0 && pkt_q == cfg_pkt_num_q) || stop_now) begin
              state_n = S_IDLE;
            end else if (cfg_gap_q != '0) begin
              state_n   = S_GAP;
              gap_cnt_n = cfg_gap_q - GAP_WIDTH'(1);
            end else begin
              state_n = S_SOP;
              do_sop  = 1'b1;
            end
          end
          S_GAP: begin
            if (stop_now) state_n = S_IDLE;
            else if (gap_cnt_q == '0) begin
              state_n = S_SOP;
              do_sop  = 1'b1;
            end else gap_cnt_n = gap_cnt_q - GAP_WIDTH'(1);
          end
          default: state_n = S_IDLE;
        endcase
      end
      if (do_sop) begin
        sop_n      = 1'b1;
        hdr_dest_n = cap_dest;
        hdr_prio_n = cap_prio;
        lfsr_n     = lfsr_adv;
        if (eff_mode == 2'd1) nd_n = nd_src + DEST_WIDTH'(1);
      end
      if (state_n == S_IDLE) stop_n = 1'b0;
      busy_n = (state_n != S_IDLE) | armed_n;
    end

    // Channel state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= S_IDLE;
        sop_q      <= 1'b0;
        eop_q      <= 1'b0;
        vld_q      <= 1'b0;
        data_q     <= '0;
        beat_q     <= '0;
        gap_cnt_q  <= '0;
        pkt_q      <= '0;
        pay_q      <= '0;
        lfsr_q     <= '0;
        nd_q       <= '0;
        hdr_dest_q <= '0;
        hdr_prio_q <= '0;
        stop_q     <= 1'b0;
        armed_q    <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        state_q    <= state_n;
        sop_q      <= sop_n;
        eop_q      <= eop_n;
        vld_q      <= vld_n;
        data_q     <= data_n;
        beat_q     <= beat_n;
        gap_cnt_q  <= gap_cnt_n;
        pkt_q      <= pkt_n;
        pay_q      <= pay_n;
        lfsr_q     <= lfsr_n;
        nd_q       <= nd_n;
        hdr_dest_q <= hdr_dest_n;
        hdr_prio_q <= hdr_prio_n;
        stop_q     <= stop_n;
        armed_q    <= armed_n;
        busy_q     <= busy_n;
      end
    end

    assign wr_sop[i] = sop_q;
    assign wr_eop[i] = eop_q;
    assign wr_vld[i] = vld_q;
    assign busy[i]   = busy_q;
    assign wr_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
  end

endmodule
